// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch/decode types, widths and PC helpers
package cpu_pkg;

  localparam int INST_ADDR_WIDTH = 32;
  localparam int INST_DATA_WIDTH = 32;

  typedef struct packed {
    logic [INST_ADDR_WIDTH-1:0] pc;
    logic [INST_DATA_WIDTH-1:0] instr;
  } If_Id_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2
  } fetch_state_e;

  // Instructions are word aligned; low two address bits are forced to zero.
  function automatic logic [INST_ADDR_WIDTH-1:0] pc_align(
    input logic [INST_ADDR_WIDTH-1:0] pc
  );
    return pc & ~(INST_ADDR_WIDTH'(3));
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bundle: IMEM port, redirect, decode handshake
interface fetch_unit_if #(
  parameter int XLEN     = 32,
  parameter int IADDR_W  = 10,
  parameter int FQ_DEPTH = 4
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  logic               start;
  logic               imem_en;
  logic [IADDR_W-1:0] imem_addr;
  logic [XLEN-1:0]    imem_data;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               id_valid;
  logic               id_ready;
  If_Id_t             id_payld;
  logic [CNT_W-1:0]   fq_count;

  modport master (
    input  start, imem_data, redirect_valid, redirect_pc, id_ready,
    output imem_en, imem_addr, id_valid, id_payld, fq_count
  );

  modport slave (
    output start, imem_data, redirect_valid, redirect_pc, id_ready,
    input  imem_en, imem_addr, id_valid, id_payld, fq_count
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - fetch queue between IMEM response and decode
module fetch_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  T                       i_push_data,
  input  logic                   i_pop,
  output T                       o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Flush wins over a simultaneous push; the pushed entry belongs to the squashed path.
  assign w_push_ok = i_push && !i_flush && (r_count != CNT_W'(DEPTH));
  assign w_pop_ok  = i_pop && !i_flush && (r_count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-based instruction fetch with redirect and decode queue
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              IADDR_W  = 10,
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master fbus
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam int CR_W  = CNT_W + 1;

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_inflight_pc;
  logic             r_inflight;
  logic [CNT_W-1:0] w_count;
  logic [CR_W-1:0]  w_credit;
  logic             w_has_credit;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_id_valid;
  If_Id_t           w_push_data;
  If_Id_t           w_head;

  // Credit counts the slot reserved by a request whose data has not landed yet.
  assign w_credit     = CR_W'(FQ_DEPTH) - {1'b0, w_count} - CR_W'(r_inflight);
  assign w_has_credit = (w_credit != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    if (!fbus.start) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_FETCH;
        S_FETCH: if (!w_has_credit) w_state_nxt = S_STALL;
        S_STALL: if (w_has_credit) w_state_nxt = S_FETCH;
        default: w_state_nxt = S_IDLE;
      endcase
    end
    if (fbus.start && w_has_credit && !fbus.redirect_valid && (r_state != S_IDLE))
      w_issue = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_pc;
      if (fbus.redirect_valid)
        r_pc <= pc_align(fbus.redirect_pc);
      else if (w_issue)
        r_pc <= r_pc + XLEN'(4);
    end
  end

  // A response landing in a redirect cycle is from the old path and is dropped.
  assign w_push      = r_inflight && !fbus.redirect_valid;
  assign w_push_data = '{pc: r_inflight_pc, instr: fbus.imem_data};
  assign w_id_valid  = (w_count != '0);
  assign w_pop       = w_id_valid && fbus.id_ready;

  fetch_fifo #(
    .T     (If_Id_t),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (fbus.redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign fbus.imem_en   = w_issue;
  assign fbus.imem_addr = r_pc[IADDR_W+1:2];
  assign fbus.id_valid  = w_id_valid;
  assign fbus.id_payld  = w_head;
  assign fbus.fq_count  = w_count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32), .IADDR_W(10), .FQ_DEPTH(4)) bus ();

  fetch_unit #(
    .XLEN     (32),
    .IADDR_W  (10),
    .FQ_DEPTH (4),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .fbus (bus)
  );

  // IMEM: word n holds value n, data returned one cycle after the strobe
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_data <= {22'd0, bus.imem_addr};
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return {22'd0, pc[11:2]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b1;
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.imem_data = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL reset_imem_en got=%b exp=0", bus.imem_en); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got=%b exp=0", bus.id_valid); end
    checks++; if (bus.fq_count !== 3'd0) begin errors++; $display("FAIL reset_fq_count got=%0d exp=0", bus.fq_count); end
    checks++; if (bus.imem_addr !== 10'd0) begin errors++; $display("FAIL reset_imem_addr got=%h exp=0", bus.imem_addr); end
  endtask

  task automatic test_basic_stream();
    logic [9:0]  exp_addr;
    logic [31:0] exp_pc;
    int first_en;
    int first_v;
    do_reset();
    bus.start = 1'b1;
    bus.id_ready = 1'b1;
    exp_addr = 10'd0;
    exp_pc = 32'd0;
    first_en = -1;
    first_v = -1;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk); #1;
      if (bus.imem_en === 1'b1) begin
        checks++; if (bus.imem_addr !== exp_addr) begin errors++; $display("FAIL basic_addr got=%h exp=%h", bus.imem_addr, exp_addr); end
        if (first_en < 0) first_en = t;
        exp_addr = exp_addr + 10'd1;
      end
      if (bus.id_valid === 1'b1) begin
        checks++; if (bus.id_payld.pc !== exp_pc || bus.id_payld.instr !== exp_instr(exp_pc)) begin
          errors++; $display("FAIL basic_payld got=%h/%h exp=%h/%h", bus.id_payld.pc, bus.id_payld.instr, exp_pc, exp_instr(exp_pc));
        end
        if (first_v < 0) first_v = t;
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++; if (first_en < 0 || first_v - first_en != 2) begin errors++; $display("FAIL basic_latency got=%0d exp=2", first_v - first_en); end
    checks++; if (exp_addr !== 10'd12) begin errors++; $display("FAIL basic_issue_count got=%0d exp=12", exp_addr); end
    checks++; if (exp_pc !== 32'd40) begin errors++; $display("FAIL basic_throughput got=%0d exp=40", exp_pc); end
  endtask

  task automatic test_backpressure();
    int n_iss;
    logic [31:0] exp_pc;
    do_reset();
    bus.start = 1'b1;
    bus.id_ready = 1'b0;
    n_iss = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk); #1;
      if (bus.imem_en === 1'b1) n_iss++;
    end
    checks++; if (n_iss != 4) begin errors++; $display("FAIL bp_issues got=%0d exp=4", n_iss); end
    checks++; if (bus.fq_count !== 3'd4) begin errors++; $display("FAIL bp_fq_count got=%0d exp=4", bus.fq_count); end
    checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL bp_imem_en got=%b exp=0", bus.imem_en); end
    checks++; if (bus.id_payld.pc !== 32'd0) begin errors++; $display("FAIL bp_head_pc got=%h exp=0", bus.id_payld.pc); end
    exp_pc = 32'd0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      bus.id_ready = 1'b1;
      #1;
      if (bus.id_valid === 1'b1) begin
        checks++; if (bus.id_payld.pc !== exp_pc || bus.id_payld.instr !== exp_instr(exp_pc)) begin
          errors++; $display("FAIL bp_release_payld got=%h/%h exp=%h/%h", bus.id_payld.pc, bus.id_payld.instr, exp_pc, exp_instr(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++; if (exp_pc !== 32'd48) begin errors++; $display("FAIL bp_release_count got=%0d exp=48", exp_pc); end
  endtask

  task automatic test_redirect();
    bit found;
    do_reset();
    bus.start = 1'b1;
    bus.id_ready = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (bus.fq_count !== 3'd3) begin errors++; $display("FAIL redir_pre_count got=%0d exp=3", bus.fq_count); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    #1;
    checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL redir_no_issue got=%b exp=0", bus.imem_en); end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b1;
    #1;
    checks++; if (bus.fq_count !== 3'd0) begin errors++; $display("FAIL redir_flush got=%0d exp=0", bus.fq_count); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL redir_id_valid got=%b exp=0", bus.id_valid); end
    checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 10'h040) begin
      errors++; $display("FAIL redir_addr got=%b/%h exp=1/040", bus.imem_en, bus.imem_addr);
    end
    found = 1'b0;
    for (int t = 0; t < 6; t++) begin
      if (!found) begin
        @(negedge clk); #1;
        if (bus.id_valid === 1'b1) found = 1'b1;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL redir_timeout got=0 exp=1"); end
    checks++; if (bus.id_payld.pc !== 32'h100 || bus.id_payld.instr !== 32'h40) begin
      errors++; $display("FAIL redir_payld got=%h/%h exp=00000100/00000040", bus.id_payld.pc, bus.id_payld.instr);
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_pc;
    do_reset();
    bus.start = 1'b1;
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 10'h3FF) begin
      errors++; $display("FAIL wrap_addr0 got=%b/%h exp=1/3ff", bus.imem_en, bus.imem_addr);
    end
    @(negedge clk); #1;
    checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 10'h000) begin
      errors++; $display("FAIL wrap_addr1 got=%b/%h exp=1/000", bus.imem_en, bus.imem_addr);
    end
    exp_pc = 32'hFFFF_FFFC;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); #1;
      if (bus.id_valid === 1'b1) begin
        checks++; if (bus.id_payld.pc !== exp_pc || bus.id_payld.instr !== exp_instr(exp_pc)) begin
          errors++; $display("FAIL wrap_payld got=%h/%h exp=%h/%h", bus.id_payld.pc, bus.id_payld.instr, exp_pc, exp_instr(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++; if (exp_pc !== 32'h0000_000C) begin errors++; $display("FAIL wrap_count got=%h exp=0000000c", exp_pc); end
  endtask

  task automatic test_reset_midop();
    bit got;
    do_reset();
    bus.start = 1'b1;
    bus.id_ready = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (bus.fq_count !== 3'd3) begin errors++; $display("FAIL midrst_pre_count got=%0d exp=3", bus.fq_count); end
    rst = 1'b0;
    #1;
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL midrst_id_valid got=%b exp=0", bus.id_valid); end
    checks++; if (bus.fq_count !== 3'd0) begin errors++; $display("FAIL midrst_fq_count got=%0d exp=0", bus.fq_count); end
    checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL midrst_imem_en got=%b exp=0", bus.imem_en); end
    @(negedge clk);
    rst = 1'b1;
    bus.id_ready = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 5; t++) begin
      if (!got) begin
        @(negedge clk); #1;
        if (bus.imem_en === 1'b1) begin
          got = 1'b1;
          checks++; if (bus.imem_addr !== 10'd0) begin errors++; $display("FAIL midrst_first_addr got=%h exp=000", bus.imem_addr); end
        end
      end
    end
    checks++; if (!got) begin errors++; $display("FAIL midrst_no_fetch got=0 exp=1"); end
    got = 1'b0;
    for (int t = 0; t < 5; t++) begin
      if (!got) begin
        @(negedge clk); #1;
        if (bus.id_valid === 1'b1) begin
          got = 1'b1;
          checks++; if (bus.id_payld.pc !== 32'd0) begin errors++; $display("FAIL midrst_first_pc got=%h exp=0", bus.id_payld.pc); end
        end
      end
    end
    checks++; if (!got) begin errors++; $display("FAIL midrst_no_valid got=0 exp=1"); end
  endtask

  task automatic test_start_toggle();
    logic [31:0] exp_pc;
    do_reset();
    bus.start = 1'b1;
    bus.id_ready = 1'b1;
    exp_pc = 32'd0;
    for (int t = 0; t < 18; t++) begin
      @(negedge clk);
      bus.start = (t >= 5 && t < 10) ? 1'b0 : 1'b1;
      #1;
      if (bus.start == 1'b0) begin
        checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL toggle_issue_while_off t=%0d got=%b exp=0", t, bus.imem_en); end
      end
      if (bus.id_valid === 1'b1) begin
        checks++; if (bus.id_payld.pc !== exp_pc || bus.id_payld.instr !== exp_instr(exp_pc)) begin
          errors++; $display("FAIL toggle_payld got=%h/%h exp=%h/%h", bus.id_payld.pc, bus.id_payld.instr, exp_pc, exp_instr(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (t == 9) begin
        checks++; if (bus.fq_count !== 3'd0 || bus.id_valid !== 1'b0) begin
          errors++; $display("FAIL toggle_drain got=%0d/%b exp=0/0", bus.fq_count, bus.id_valid);
        end
      end
    end
    checks++; if (exp_pc !== 32'd40) begin errors++; $display("FAIL toggle_count got=%0d exp=40", exp_pc); end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_redirect();
    test_pc_wrap();
    test_reset_midop();
    test_start_toggle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, PC and instruction width.
REQ-002 Parameter IADDR_W, default 10, IMEM word-address width.
REQ-003 Parameter FQ_DEPTH, default 4, fetch-queue entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-005 clk  input  1  clock; all state updates on posedge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  fetch enable; 0 halts new IMEM requests.
REQ-008 imem_en  output  1  IMEM read strobe.
REQ-009 imem_addr  output  IADDR_W  word address, equal to pc[IADDR_W+1:2].
REQ-010 imem_data  input  XLEN  read data, valid exactly 1 cycle after imem_en.
REQ-011 redirect_valid  input  1  branch/jump redirect from EX.
REQ-012 redirect_pc  input  XLEN  redirect target.
REQ-013 id_valid  output  1  queue head valid towards decode.
REQ-014 id_ready  input  1  decode accepts the head.
REQ-015 id_payld  output  If_Id_t  head {pc, instr}.
REQ-016 fq_count  output  $clog2(FQ_DEPTH)+1  current queue occupancy.

Function
REQ-017 States: IDLE (start=0), FETCH (issuing), STALL (no credit); IDLE->FETCH on start=1; FETCH<->STALL on credit; any state->IDLE on start=0 (queue drains normally).
REQ-018 Credit = FQ_DEPTH - fq_count - inflight, where inflight (0/1) marks a request issued last cycle not yet written.
REQ-019 issue = start & credit>0 & !redirect_valid; imem_en = issue.
REQ-020 On issue, pc <= pc + 4, 32-bit modulo (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-021 The cycle after an unsquashed issue, {issue pc, imem_data} is pushed to the queue tail.
REQ-022 Decode pop occurs when id_valid & id_ready; id_valid = (fq_count != 0); id_payld = head entry, stable while id_valid & !id_ready.
REQ-023 Push and pop in the same cycle leave fq_count unchanged; overflow is impossible by credit rule.
REQ-024 Redirect cycle: pc <= {redirect_pc[XLEN-1:2], 2'b00}; queue flushed (fq_count <= 0); no issue; any inflight response arriving next cycle is discarded.
REQ-025 Redirect has priority over push, pop and start=0; id_valid is 0 in the cycle after redirect.
REQ-026 Fetch-to-decode latency: first instr at id_valid 2 cycles after issue (IMEM 1 + queue 1).
REQ-027 Steady-state throughput 1 instr/cycle when id_ready=1 continuously.

Reset
REQ-028 While rst=0: pc=RESET_PC, queue empty, fq_count=0, inflight=0, id_valid=0, imem_en=0, state IDLE.
REQ-029 Reset mid-operation discards all queued and inflight instructions; first post-reset fetch address is RESET_PC.

Structure
REQ-030 If_Id_t {pc[XLEN-1:0], instr[XLEN-1:0]}, INST_ADDR_WIDTH and INST_DATA_WIDTH reside in cpu_pkg.
REQ-031 Queue is sub-module fetch_fifo (parametrised type, depth; push, pop, flush, count).
REQ-032 pc, inflight tag and state FSM reside in fetch_unit top.

Verification
REQ-033 Reset release, start=1, id_ready=1, IMEM word n = n -> imem_addr 0,1,2..., id_payld pc 0,4,8 with instr 0,1,2, first id_valid 2 cycles after first imem_en.
REQ-034 id_ready=0 for 10 cycles -> fq_count saturates at 4, imem_en stays 0 after 4 issues, no lost or duplicated pc on release.
REQ-035 redirect_valid with redirect_pc=0x0000_0103 while queue full -> queue flushed, inflight discarded, next imem_addr 0x40, next id_payld.pc 0x100.
REQ-036 pc=0xFFFF_FFFC with start=1 -> following issue pc 0x0000_0000.
REQ-037 rst asserted with 3 queued entries and inflight request -> id_valid 0 immediately, fq_count 0, first fetch after release at RESET_PC.
REQ-038 start toggled 1,0,1 with id_ready=1 -> no issue while start=0, queue drains, ordering of pcs continuous.
